// File: rtl/cal_ht_update.sv
// rtl/cal_ht_update.sv - GRU hidden-state update: ht = ht1 + zt*(h~t - ht1), one cell per cycle
module cal_ht_update #(
    parameter int CELLNUM = 4,
    parameter int DATABIT = 16,
    parameter int FRACBIT = 13,
    parameter int STEP    = 10,
    parameter int HTNUM   = CELLNUM * DATABIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      htb_valid,
    input  logic signed [DATABIT-1:0] htb_data,
    input  logic        [HTNUM-1:0]   zt,
    output logic                      htb_ready,
    output logic        [HTNUM-1:0]   ht_out,
    output logic                      ht_valid,
    output logic        [3:0]         step_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      drop_err
);

    localparam int IDXW = (CELLNUM > 1) ? $clog2(CELLNUM) : 1;
    localparam int PW   = 2 * DATABIT + 1;   // product width
    localparam int SW   = PW + 1;            // sum width, never overflows
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(CELLNUM - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DATABIT - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, UPDATE, COMMIT} state_t;

    state_t                    state_q;
    logic [IDXW-1:0]           idx_q;
    logic signed [DATABIT-1:0] htb_buf_q [CELLNUM];
    logic signed [DATABIT-1:0] z_buf_q   [CELLNUM];
    logic signed [DATABIT-1:0] new_buf_q [CELLNUM];
    logic [HTNUM-1:0]          ht_out_q;
    logic                      ht_valid_q;
    logic [3:0]                step_cnt_q;
    logic                      done_q;
    logic                      drop_q;

    logic signed [DATABIT-1:0] ht_cur;
    logic signed [DATABIT:0]   diff;
    logic signed [PW-1:0]      z_ext;
    logic signed [PW-1:0]      d_ext;
    logic signed [PW-1:0]      prod;
    logic signed [PW-1:0]      shifted;
    logic signed [SW-1:0]      sum_w;
    logic signed [DATABIT-1:0] cell_res;
    logic [HTNUM-1:0]          new_packed;

    // Single shared datapath for the cell selected by idx_q, saturated to the word range
    always_comb begin
        ht_cur   = $signed(ht_out_q[idx_q*DATABIT +: DATABIT]);
        diff     = {htb_buf_q[idx_q][DATABIT-1], htb_buf_q[idx_q]} - {ht_cur[DATABIT-1], ht_cur};
        z_ext    = {{(DATABIT+1){z_buf_q[idx_q][DATABIT-1]}}, z_buf_q[idx_q]};
        d_ext    = {{DATABIT{diff[DATABIT]}}, diff};
        prod     = z_ext * d_ext;
        shifted  = prod >>> FRACBIT;
        sum_w    = {{(SW-DATABIT){ht_cur[DATABIT-1]}}, ht_cur} + {shifted[PW-1], shifted};
        cell_res = sum_w[DATABIT-1:0];
        if (sum_w > SAT_MAX) begin
            cell_res = SAT_MAX[DATABIT-1:0];
        end else if (sum_w < SAT_MIN) begin
            cell_res = SAT_MIN[DATABIT-1:0];
        end
    end

    // Repack the per-cell results into the state word committed at the end of a step
    always_comb begin
        new_packed = '0;
        for (int i = 0; i < CELLNUM; i++) begin
            new_packed[i*DATABIT +: DATABIT] = new_buf_q[i];
        end
    end

    // Step sequencer: collect candidates, update cell by cell, commit; start always restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ht_out_q   <= '0;
            ht_valid_q <= 1'b0;
            step_cnt_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            for (int i = 0; i < CELLNUM; i++) begin
                htb_buf_q[i] <= '0;
                z_buf_q[i]   <= '0;
                new_buf_q[i] <= '0;
            end
        end else begin
            ht_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (start) begin
                state_q    <= COLLECT;
                idx_q      <= '0;
                ht_out_q   <= '0;
                step_cnt_q <= '0;
                drop_q     <= 1'b0;
                for (int i = 0; i < CELLNUM; i++) begin
                    htb_buf_q[i] <= '0;
                    z_buf_q[i]   <= '0;
                    new_buf_q[i] <= '0;
                end
            end else begin
                if (htb_valid && state_q != COLLECT) begin
                    drop_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                    end
                    COLLECT: begin
                        if (htb_valid) begin
                            htb_buf_q[idx_q] <= htb_data;
                            if (idx_q == '0) begin
                                for (int i = 0; i < CELLNUM; i++) begin
                                    z_buf_q[i] <= $signed(zt[i*DATABIT +: DATABIT]);
                                end
                            end
                            if (idx_q == IDX_LAST) begin
                                idx_q   <= '0;
                                state_q <= UPDATE;
                            end else begin
                                idx_q <= idx_q + IDXW'(1);
                            end
                        end
                    end
                    UPDATE: begin
                        new_buf_q[idx_q] <= cell_res;
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= COMMIT;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                    COMMIT: begin
                        ht_out_q   <= new_packed;
                        ht_valid_q <= 1'b1;
                        step_cnt_q <= step_cnt_q + 4'd1;
                        if (step_cnt_q == 4'(STEP - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign htb_ready = (state_q == COLLECT);
    assign busy      = (state_q != IDLE);
    assign ht_out    = ht_out_q;
    assign ht_valid  = ht_valid_q;
    assign step_cnt  = step_cnt_q;
    assign done      = done_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_cal_ht_update.sv
// tb/tb_cal_ht_update.sv - directed table-driven bench for cal_ht_update
module tb_cal_ht_update;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               htb_valid;
    logic signed [15:0] htb_data;
    logic [63:0]        zt;
    logic               htb_ready;
    logic [63:0]        ht_out;
    logic               ht_valid;
    logic [3:0]         step_cnt;
    logic               busy;
    logic               done;
    logic               drop_err;

    int n_chk;
    int n_fail;

    cal_ht_update dut (
        .clk(clk), .rst_n(rst_n), .start(start), .htb_valid(htb_valid),
        .htb_data(htb_data), .zt(zt), .htb_ready(htb_ready), .ht_out(ht_out),
        .ht_valid(ht_valid), .step_cnt(step_cnt), .busy(busy), .done(done),
        .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] zt;
        logic [63:0] htb;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [63:0] pk(int a, int b, int c, int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [63:0] rep(int a);
        return pk(a, a, a, a);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives the four candidates on consecutive cycles; returns at the negedge after the last accept
    task automatic send_samples(logic [63:0] z, logic [63:0] h);
        for (int i = 0; i < 4; i++) begin
            htb_valid = 1'b1;
            htb_data  = h[i*16 +: 16];
            zt        = (i == 0) ? z : 64'h0;
            @(negedge clk);
        end
        htb_valid = 1'b0;
        htb_data  = '0;
    endtask

    // Counts cycles from the last accept until ht_valid, bounded
    task automatic wait_valid(input logic inject, output int lat);
        lat = 0;
        if (inject) begin
            htb_valid = 1'b1;
            htb_data  = 16'sh7fff;
            @(negedge clk);
            lat = 1;
            htb_valid = 1'b0;
            if (ht_valid) return;
        end
        do begin
            @(negedge clk);
            lat++;
        end while (!ht_valid && lat < 20);
    endtask

    task automatic run_step(string name, logic [63:0] z, logic [63:0] h, logic [63:0] exp, logic inject);
        int lat;
        send_samples(z, h);
        wait_valid(inject, lat);
        chk({name, " latency"}, 64'(lat), 64'd5);
        chk({name, " ht_out"}, ht_out, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        n_chk  = 0;
        n_fail = 0;
        rst_n = 1'b0; start = 1'b0; htb_valid = 1'b0; htb_data = '0; zt = '0;

        vecs[0] = '{zt: rep(0),     htb: pk(4096, -4096, 8192, 100), exp: rep(0)};
        vecs[1] = '{zt: rep(8192),  htb: pk(4096, -4096, 8192, 100), exp: pk(4096, -4096, 8192, 100)};
        vecs[2] = '{zt: rep(8192),  htb: rep(0),      exp: rep(0)};
        vecs[3] = '{zt: rep(4096),  htb: rep(4096),   exp: rep(2048)};
        vecs[4] = '{zt: rep(4096),  htb: rep(4096),   exp: rep(3072)};
        vecs[5] = '{zt: rep(8192),  htb: rep(0),      exp: rep(0)};
        vecs[6] = '{zt: rep(4096),  htb: rep(-4096),  exp: rep(-2048)};
        vecs[7] = '{zt: rep(8192),  htb: rep(-8192),  exp: rep(-8192)};
        vecs[8] = '{zt: rep(32767), htb: rep(8192),   exp: rep(32767)};
        vecs[9] = '{zt: rep(32767), htb: rep(-32768), exp: rep(-32768)};

        #1;
        chk("rst ht_out", ht_out, 64'h0);
        chk("rst flags", {56'h0, ht_valid, done, busy, drop_err, htb_ready, 3'b0}, 64'h0);
        chk("rst step_cnt", 64'(step_cnt), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full ten-step sequence driven from the vector table
        pulse_start();
        chk("start busy/ready", {62'h0, busy, htb_ready}, 64'h3);
        for (int k = 0; k < 10; k++) begin
            send_samples(vecs[k].zt, vecs[k].htb);
            wait_valid(1'b0, lat);
            chk($sformatf("step%0d latency", k), 64'(lat), 64'd5);
            chk($sformatf("step%0d ht_out", k), ht_out, vecs[k].exp);
            chk($sformatf("step%0d done", k), 64'(done), 64'(k == 9));
            chk($sformatf("step%0d step_cnt", k), 64'(step_cnt), 64'(k + 1));
            @(negedge clk);
            chk($sformatf("step%0d pulse", k), 64'(ht_valid), 64'h0);
            chk($sformatf("step%0d hold", k), ht_out, vecs[k].exp);
        end
        chk("seq end busy/ready/done", {61'h0, busy, htb_ready, done}, 64'h0);
        chk("seq end step_cnt", 64'(step_cnt), 64'd10);
        chk("seq end drop_err", 64'(drop_err), 64'h0);

        // Negative saturation, then a dropped sample during UPDATE
        pulse_start();
        chk("restart step_cnt", 64'(step_cnt), 64'h0);
        run_step("mir0", rep(8192), rep(8192), rep(8192), 1'b0);
        run_step("mir1", rep(32767), rep(-8192), rep(-32768), 1'b0);
        run_step("drop", rep(8192), rep(100), rep(100), 1'b1);
        chk("drop_err set", 64'(drop_err), 64'h1);

        // start mid-COLLECT with a coincident sample: start wins, idx restarts
        @(negedge clk);
        htb_valid = 1'b1; htb_data = 16'sd1000; zt = rep(8192);
        @(negedge clk);
        htb_data = 16'sd2000;
        @(negedge clk);
        start = 1'b1; htb_data = 16'sd3000;
        @(negedge clk);
        start = 1'b0; htb_valid = 1'b0;
        chk("abort ht_out", ht_out, 64'h0);
        chk("abort step_cnt", 64'(step_cnt), 64'h0);
        chk("abort drop/ready", {62'h0, drop_err, htb_ready}, 64'h1);
        run_step("after abort", rep(4096), rep(4096), rep(2048), 1'b0);

        // Reset in the middle of UPDATE
        send_samples(rep(8192), rep(500));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst ht_out", ht_out, 64'h0);
        chk("mid rst flags", {58'h0, ht_valid, done, busy, drop_err, htb_ready, step_cnt != 4'd0}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ht_valid || done) pulses++;
        end
        chk("no pulse after rst", 64'(pulses), 64'h0);
        chk("idle after rst", {63'h0, busy}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
